bank_rd_return: RTL and testbench

- Downstream consumer of the delayed bank-select lines in the multi-bank memory read path.
- Tracks each issued read through the bank read latency and selects the returning bank's data with the aligned select.
- Buffers results in a first-word-fall-through FIFO and presents them on a ready/valid channel.
- Issues read credit upstream so the FIFO never overflows under consumer backpressure.

---
 rtl/mb_pkg.sv | 19 +
 rtl/bank_rd_return_if.sv | 24 ++
 rtl/rd_return_fifo.sv | 54 +++++
 rtl/bank_rd_return.sv | 82 ++++++++
 tb/tb_bank_rd_return.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/mb_pkg.sv
// Shared constants and helpers for the multi-bank read-return path.
package mb_pkg;

   // Bank count must be a power of two addressed exactly by the select width.
   function automatic bit sel_ok(int num_banks, int sel_width);
      return (num_banks >= 2) && (num_banks == (1 << sel_width));
   endfunction

   // LSB of bank k's word inside the concatenated read bus.
   function automatic int bank_lsb(int sel, int data_width);
      return sel * data_width;
   endfunction

   // Width needed to hold an occupancy of 0..depth inclusive.
   function automatic int cnt_w(int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/bank_rd_return_if.sv
// Read-return handshake bundle: upstream issue/credit, bank data, downstream ready/valid.
interface bank_rd_return_if #(
   parameter int NUM_BANKS  = 4,
   parameter int SEL_WIDTH  = 2,
   parameter int DATA_WIDTH = 8
) ();
   logic                            i_rd_req;
   logic                            o_rd_ready;
   logic [SEL_WIDTH-1:0]            i_sel;
   logic [NUM_BANKS*DATA_WIDTH-1:0] i_bank_rdata;
   logic [DATA_WIDTH-1:0]           o_rdata;
   logic                            o_rvalid;
   logic                            i_rready;

   modport master (
      output i_rd_req, i_sel, i_bank_rdata, i_rready,
      input  o_rd_ready, o_rdata, o_rvalid
   );

   modport slave (
      input  i_rd_req, i_sel, i_bank_rdata, i_rready,
      output o_rd_ready, o_rdata, o_rvalid
   );
endinterface

// File: rtl/rd_return_fifo.sv
// First-word-fall-through FIFO holding returned bank words until the consumer takes them.
module rd_return_fifo
   import mb_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        push,
   input  logic                        pop,
   input  logic [DATA_WIDTH-1:0]       din,
   output logic [DATA_WIDTH-1:0]       dout,
   output logic                        empty,
   output logic                        full,
   output logic [$clog2(FIFO_DEPTH):0] count
);
   localparam int CW = cnt_w(FIFO_DEPTH);
   localparam int AW = $clog2(FIFO_DEPTH);

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]         wptr, rptr;
   logic                  do_push, do_pop;

   // Pop on empty is ignored; push on full is ignored so occupancy can never exceed depth.
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign empty   = (count == '0);
   assign full    = (count == CW'(FIFO_DEPTH));
   assign dout    = empty ? '0 : mem[rptr];

   // Storage needs no reset: the head is masked to zero while empty.
   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= din;
   end

   // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/bank_rd_return.sv
// Tracks issued bank reads through the read latency, captures the selected bank word,
// buffers it for a ready/valid consumer and meters upstream credit so the buffer never overflows.
module bank_rd_return
   import mb_pkg::*;
#(
   parameter int NUM_BANKS    = 4,
   parameter int SEL_WIDTH    = 2,
   parameter int DATA_WIDTH   = 8,
   parameter int READ_LATENCY = 2,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   bank_rd_return_if.slave             bus,
   output logic [$clog2(FIFO_DEPTH):0] o_inflight,
   output logic                        o_err_drop
);
   localparam int CW = cnt_w(FIFO_DEPTH);

   if (!sel_ok(NUM_BANKS, SEL_WIDTH)) begin : g_bad_cfg
      $error("bank_rd_return: NUM_BANKS must equal 2**SEL_WIDTH and be >= 2");
   end

   logic [READ_LATENCY-1:0] vld_pipe;
   logic                    accept, ret_vld, push;
   logic [DATA_WIDTH-1:0]   sel_data;
   logic [CW-1:0]           pipe_cnt, fifo_count;
   logic                    fifo_empty, fifo_full;

   assign accept   = bus.i_rd_req & bus.o_rd_ready;
   assign ret_vld  = vld_pipe[READ_LATENCY-1];
   assign sel_data = bus.i_bank_rdata[bank_lsb(int'(bus.i_sel), DATA_WIDTH) +: DATA_WIDTH];
   // Credit guarantees the FIFO has room when a read returns; the full gate is a backstop.
   assign push     = ret_vld & ~fifo_full;

   if (READ_LATENCY == 1) begin : g_pipe1
      // Single-stage latency: the accepted request is itself the return marker.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) vld_pipe <= '0;
         else        vld_pipe <= accept;
      end
   end else begin : g_pipeN
      // Shift accepted requests toward the return stage, one stage per cycle.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) vld_pipe <= '0;
         else        vld_pipe <= {vld_pipe[READ_LATENCY-2:0], accept};
      end
   end

   // Count reads still travelling through the bank latency.
   always_comb begin
      pipe_cnt = '0;
      for (int i = 0; i < READ_LATENCY; i++) pipe_cnt = pipe_cnt + CW'(vld_pipe[i]);
   end

   // Credit comes from registered state only, so a pop frees a slot the following cycle.
   assign o_inflight     = pipe_cnt + fifo_count;
   assign bus.o_rd_ready = (o_inflight < CW'(FIFO_DEPTH));
   assign bus.o_rvalid   = ~fifo_empty;

   // Sticky record that upstream ignored the credit and a read was lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                o_err_drop <= 1'b0;
      else if (bus.i_rd_req && !bus.o_rd_ready) o_err_drop <= 1'b1;
   end

   rd_return_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (bus.o_rvalid & bus.i_rready),
      .din   (sel_data),
      .dout  (bus.o_rdata),
      .empty (fifo_empty),
      .full  (fifo_full),
      .count (fifo_count)
   );

endmodule

// File: tb/tb_bank_rd_return.sv
// Self-checking bench for bank_rd_return against a queue-based reference model.
module tb_bank_rd_return;
   localparam int NB = 4;
   localparam int SW = 2;
   localparam int DW = 8;
   localparam int L  = 2;
   localparam int D  = 4;
   localparam int CW = $clog2(D) + 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [CW-1:0] inflight;
   logic          err_drop;

   always #5 clk = ~clk;

   bank_rd_return_if #(.NUM_BANKS(NB), .SEL_WIDTH(SW), .DATA_WIDTH(DW)) bus ();

   bank_rd_return #(
      .NUM_BANKS(NB), .SEL_WIDTH(SW), .DATA_WIDTH(DW), .READ_LATENCY(L), .FIFO_DEPTH(D)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .o_inflight (inflight),
      .o_err_drop (err_drop)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: issue cycles of accepted reads, buffered words, sticky drop flag.
   int          pend[$];
   logic [DW-1:0] fq[$];
   bit          m_err = 1'b0;
   int          cyc = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_outputs(input string ph);
      int occ;
      occ = pend.size() + fq.size();
      check({ph, "_rvalid"},   32'(bus.o_rvalid),   32'(fq.size() > 0));
      check({ph, "_rdata"},    32'(bus.o_rdata),    (fq.size() > 0) ? 32'(fq[0]) : 32'h0);
      check({ph, "_inflight"}, 32'(inflight),       32'(occ));
      check({ph, "_rd_ready"}, 32'(bus.o_rd_ready), 32'(occ < D));
      check({ph, "_err_drop"}, 32'(err_drop),       32'(m_err));
   endtask

   // Apply one clock edge's worth of the rules to the model, using the inputs held this cycle.
   task automatic model_edge();
      bit ready, ret;
      logic [DW-1:0] d;
      ready = (pend.size() + fq.size()) < D;
      ret   = (pend.size() > 0) && (pend[0] + L == cyc);
      d     = bus.i_bank_rdata[int'(bus.i_sel)*DW +: DW];
      if (ret) check("push_not_full", 32'(fq.size() < D), 32'h1);
      if (fq.size() > 0 && bus.i_rready) void'(fq.pop_front());
      if (ret) begin
         void'(pend.pop_front());
         fq.push_back(d);
      end
      if (bus.i_rd_req) begin
         if (ready) pend.push_back(cyc);
         else       m_err = 1'b1;
      end
      cyc++;
   endtask

   // Called at posedge+1: drive inputs, check at negedge, advance model at the next posedge.
   task automatic step(input bit req, input bit rready, input logic [SW-1:0] sel,
                       input logic [NB*DW-1:0] data, input string ph);
      bus.i_rd_req     = req;
      bus.i_rready     = rready;
      bus.i_sel        = sel;
      bus.i_bank_rdata = data;
      @(negedge clk);
      check_outputs(ph);
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle(input int n, input string ph);
      for (int i = 0; i < n; i++) step(1'b0, 1'b1, SW'($urandom), $urandom, ph);
   endtask

   initial begin
      bus.i_rd_req     = 1'b0;
      bus.i_rready     = 1'b0;
      bus.i_sel        = '0;
      bus.i_bank_rdata = '0;
      #1;
      check("rst_rvalid",   32'(bus.o_rvalid),   32'h0);
      check("rst_rdata",    32'(bus.o_rdata),    32'h0);
      check("rst_inflight", 32'(inflight),       32'h0);
      check("rst_rd_ready", 32'(bus.o_rd_ready), 32'h1);
      check("rst_err_drop", 32'(err_drop),       32'h0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Single read returning bank 2.
      step(1'b1, 1'b1, 2'd0, 32'h0, "single");
      step(1'b0, 1'b1, 2'd0, 32'h0, "single");
      step(1'b0, 1'b1, 2'd2, 32'h00A5_0000, "single");
      check("single_rdata_c3", 32'(bus.o_rdata), 32'hA5);
      idle(3, "single_tail");

      // Back-to-back reads across all four banks.
      for (int k = 0; k < 6; k++)
         step(k < 4, 1'b1, SW'(k - 2), 32'h1312_1110, "b2b");
      idle(3, "b2b_tail");

      // Backpressure: request every cycle with the consumer stalled.
      for (int k = 0; k < 6; k++)
         step(1'b1, 1'b0, SW'($urandom), $urandom, "bp");
      check("bp_inflight", 32'(inflight),       32'h4);
      check("bp_rd_ready", 32'(bus.o_rd_ready), 32'h0);
      check("bp_err_drop", 32'(err_drop),       32'h1);
      check("bp_rvalid",   32'(bus.o_rvalid),   32'h1);

      // Drain from full.
      for (int k = 0; k < 6; k++)
         step(1'b0, 1'b1, SW'($urandom), $urandom, "drain");

      // Steady one-per-cycle stream: simultaneous push/pop, pointers wrap.
      for (int k = 0; k < 24; k++)
         step(1'b1, 1'b1, SW'($urandom), $urandom, "steady");
      check("steady_inflight", 32'(inflight), 32'h3);
      idle(4, "steady_tail");

      // Randomized traffic and backpressure.
      for (int k = 0; k < 300; k++)
         step($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 5, SW'($urandom), $urandom, "rand");
      idle(8, "rand_tail");

      // Reset with two reads in the pipe and two words buffered.
      for (int k = 0; k < 4; k++)
         step(1'b1, 1'b0, SW'($urandom), $urandom, "prerst");
      check("prerst_inflight", 32'(inflight), 32'h4);
      rst_n = 1'b0;
      #1;
      check("midrst_rvalid",   32'(bus.o_rvalid), 32'h0);
      check("midrst_inflight", 32'(inflight),     32'h0);
      check("midrst_err_drop", 32'(err_drop),     32'h0);
      pend.delete();
      fq.delete();
      m_err = 1'b0;
      @(posedge clk);
      cyc++;
      #1;
      rst_n = 1'b1;
      idle(6, "postrst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
